// File: rtl/instr_cycle_seq_pkg.sv
// Shared encodings for the instruction-cycle sequencer: phases, addressing modes
// and memory address sources.
package instr_cycle_seq_pkg;

    typedef enum logic [1:0] {
        PH_FI  = 2'd0,
        PH_SRC = 2'd1,
        PH_DST = 2'd2,
        PH_EXC = 2'd3
    } phase_t;

    typedef enum logic [1:0] {
        MODE_REG     = 2'd0,
        MODE_IND     = 2'd1,
        MODE_AUTOINC = 2'd2,
        MODE_DEFER   = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        AS_PC  = 2'd0,
        AS_REG = 2'd1,
        AS_MDR = 2'd2
    } addr_sel_t;

    // Phase that follows the current one; register-mode operands are skipped.
    function automatic phase_t phase_after(phase_t cur, logic [1:0] src_mode,
                                           logic [1:0] dst_mode);
        if (cur == PH_FI && src_mode != MODE_REG)
            return PH_SRC;
        else if (cur != PH_DST && dst_mode != MODE_REG)
            return PH_DST;
        else
            return PH_EXC;
    endfunction

endpackage

// File: rtl/instr_cycle_seq_mem_access_timer.sv
// Watches the memory handshake: strobes done on an accepted ack and timeout when
// a request has waited TMO_MAX cycles without one (TMO_MAX of 0 disables it).
module mem_access_timer #(
    parameter int TMO_W   = 4,
    parameter int TMO_MAX = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic ack,
    output logic done,
    output logic timeout
);

    localparam logic [TMO_W:0] LIMIT = (TMO_W+1)'(TMO_MAX);

    logic [TMO_W-1:0] cnt;
    logic             at_limit;

    // The cycle that would bring the count to the limit is the terminal one.
    assign at_limit = (LIMIT != '0) && (({1'b0, cnt} + (TMO_W+1)'(1)) >= LIMIT);
    assign done     = req & ack;
    assign timeout  = req & ~ack & at_limit;

    always_ff @(posedge clk) begin
        if (rst || !req || ack)
            cnt <= '0;
        else if (cnt != '1)
            cnt <= cnt + TMO_W'(1);
    end

endmodule

// File: rtl/instr_cycle_seq.sv
// Instruction-cycle sequencer: walks fetch/source/destination/execute phases,
// drives the memory handshake and issues one-cycle phase-set pulses.
module instr_cycle_seq
    import instr_cycle_seq_pkg::*;
#(
    parameter int TMO_W   = 4,
    parameter int TMO_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       halt,
    input  logic [1:0] ir_src_mode,
    input  logic [1:0] ir_dst_mode,
    output logic       mem_req,
    input  logic       mem_ack,
    output logic [1:0] addr_sel,
    output logic       ir_ld,
    output logic       opr_ld,
    output logic       reg_inc,
    output logic       exc_go,
    input  logic       exc_done,
    output logic       fi0,
    output logic       src0,
    output logic       dst0,
    output logic       exc0,
    output logic [1:0] phase,
    output logic       bus_err
);

    typedef enum logic [2:0] {
        S_FI_IDLE,
        S_FI_REQ,
        S_FI_LOAD,
        S_OPR_REQ,
        S_OPR_GAP,
        S_OPR_LOAD,
        S_EXC
    } state_t;

    state_t    state, state_n;
    phase_t    phase_q, phase_n, target;
    addr_sel_t addr_sel_q, addr_sel_n;
    mode_t     cur_mode;
    logic      step, step_n;
    logic      enter, acc_done, acc_tmo;
    logic      mem_req_n, ir_ld_n, opr_ld_n, reg_inc_n, exc_go_n;
    logic      fi0_n, src0_n, dst0_n, exc0_n, bus_err_n;

    assign addr_sel = addr_sel_q;
    assign phase    = phase_q;
    assign cur_mode = mode_t'((phase_q == PH_SRC) ? ir_src_mode : ir_dst_mode);
    assign target   = phase_after(phase_q, ir_src_mode, ir_dst_mode);

    mem_access_timer #(
        .TMO_W   (TMO_W),
        .TMO_MAX (TMO_MAX)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .req     (mem_req),
        .ack     (mem_ack),
        .done    (acc_done),
        .timeout (acc_tmo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_FI_IDLE;
            step       <= 1'b0;
            phase_q    <= PH_FI;
            addr_sel_q <= AS_PC;
            mem_req    <= 1'b0;
            ir_ld      <= 1'b0;
            opr_ld     <= 1'b0;
            reg_inc    <= 1'b0;
            exc_go     <= 1'b0;
            fi0        <= 1'b1;
            src0       <= 1'b0;
            dst0       <= 1'b0;
            exc0       <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            state      <= state_n;
            step       <= step_n;
            phase_q    <= phase_n;
            addr_sel_q <= addr_sel_n;
            mem_req    <= mem_req_n;
            ir_ld      <= ir_ld_n;
            opr_ld     <= opr_ld_n;
            reg_inc    <= reg_inc_n;
            exc_go     <= exc_go_n;
            fi0        <= fi0_n;
            src0       <= src0_n;
            dst0       <= dst0_n;
            exc0       <= exc0_n;
            bus_err    <= bus_err_n;
        end
    end

    always_comb begin
        state_n    = state;
        step_n     = step;
        phase_n    = phase_q;
        addr_sel_n = addr_sel_q;
        mem_req_n  = mem_req;
        exc_go_n   = exc_go;
        ir_ld_n    = 1'b0;
        opr_ld_n   = 1'b0;
        reg_inc_n  = 1'b0;
        fi0_n      = 1'b0;
        src0_n     = 1'b0;
        dst0_n     = 1'b0;
        exc0_n     = 1'b0;
        bus_err_n  = 1'b0;
        enter      = 1'b0;

        unique case (state)
            S_FI_IDLE: begin
                if (!halt) begin
                    mem_req_n  = 1'b1;
                    addr_sel_n = AS_PC;
                    state_n    = S_FI_REQ;
                end
            end
            S_FI_REQ: begin
                if (acc_done) begin
                    mem_req_n = 1'b0;
                    ir_ld_n   = 1'b1;
                    state_n   = S_FI_LOAD;
                end
            end
            S_FI_LOAD, S_OPR_LOAD: enter = 1'b1;
            S_OPR_REQ: begin
                if (acc_done) begin
                    mem_req_n = 1'b0;
                    // Deferred mode fetches the pointer first, then the operand via MDR.
                    if (cur_mode == MODE_DEFER && !step) begin
                        step_n     = 1'b1;
                        addr_sel_n = AS_MDR;
                        state_n    = S_OPR_GAP;
                    end else begin
                        opr_ld_n  = 1'b1;
                        reg_inc_n = (cur_mode == MODE_AUTOINC);
                        state_n   = S_OPR_LOAD;
                    end
                end
            end
            S_OPR_GAP: begin
                mem_req_n = 1'b1;
                state_n   = S_OPR_REQ;
            end
            S_EXC: begin
                if (exc_go && exc_done) begin
                    exc_go_n   = 1'b0;
                    phase_n    = PH_FI;
                    fi0_n      = 1'b1;
                    mem_req_n  = !halt;
                    addr_sel_n = AS_PC;
                    state_n    = halt ? S_FI_IDLE : S_FI_REQ;
                end
            end
            default: state_n = S_FI_IDLE;
        endcase

        if (enter) begin
            phase_n = target;
            step_n  = 1'b0;
            if (target == PH_EXC) begin
                exc0_n   = 1'b1;
                exc_go_n = 1'b1;
                state_n  = S_EXC;
            end else begin
                src0_n     = (target == PH_SRC);
                dst0_n     = (target == PH_DST);
                mem_req_n  = 1'b1;
                addr_sel_n = AS_REG;
                state_n    = S_OPR_REQ;
            end
        end

        // A hung access abandons the whole instruction and restarts at fetch.
        if (acc_tmo) begin
            mem_req_n = 1'b0;
            bus_err_n = 1'b1;
            fi0_n     = 1'b1;
            phase_n   = PH_FI;
            step_n    = 1'b0;
            state_n   = S_FI_IDLE;
        end
    end

endmodule

// File: tb/tb_instr_cycle_seq.sv
// Self-checking bench: a cycle-level expected trace is built from per-instruction
// access rules, then replayed against the sequencer with random ignored-input noise.
module tb_instr_cycle_seq;

    localparam int TMO_W   = 4;
    localparam int TMO_MAX = 15;

    localparam logic [1:0] F = 2'd0, S = 2'd1, D = 2'd2, E = 2'd3;

    logic       clk = 1'b0;
    logic       rst, halt, mem_ack, exc_done;
    logic [1:0] ir_src_mode, ir_dst_mode;
    logic       mem_req, ir_ld, opr_ld, reg_inc, exc_go;
    logic       fi0, src0, dst0, exc0, bus_err;
    logic [1:0] addr_sel, phase;

    always #5 clk = ~clk;

    instr_cycle_seq #(.TMO_W(TMO_W), .TMO_MAX(TMO_MAX)) dut (
        .clk         (clk),
        .rst         (rst),
        .halt        (halt),
        .ir_src_mode (ir_src_mode),
        .ir_dst_mode (ir_dst_mode),
        .mem_req     (mem_req),
        .mem_ack     (mem_ack),
        .addr_sel    (addr_sel),
        .ir_ld       (ir_ld),
        .opr_ld      (opr_ld),
        .reg_inc     (reg_inc),
        .exc_go      (exc_go),
        .exc_done    (exc_done),
        .fi0         (fi0),
        .src0        (src0),
        .dst0        (dst0),
        .exc0        (exc0),
        .phase       (phase),
        .bus_err     (bus_err)
    );

    typedef struct packed {
        logic       mem_req;
        logic [1:0] addr_sel;
        logic       ir_ld, opr_ld, reg_inc, exc_go;
        logic       fi0, src0, dst0, exc0;
        logic [1:0] phase;
        logic       bus_err;
    } outs_t;

    typedef struct packed {
        logic       rst, halt, mem_ack, exc_done;
        logic [1:0] src, dst;
    } ins_t;

    typedef struct packed {
        ins_t  i;
        outs_t o;
        logic  as_care;
    } step_t;

    step_t      plan[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         waits[5];
    logic [1:0] cur_src, cur_dst;
    logic       next_fi0;

    function automatic outs_t base(logic [1:0] ph);
        outs_t o;
        o = '0;
        o.phase = ph;
        return o;
    endfunction

    // Ack is noise whenever no request is out; exc_done is noise while not executing.
    function automatic void add(outs_t o, logic rst_v, logic halt_v, logic ack_v,
                                logic done_v, logic as_care);
        step_t s;
        s.i.rst      = rst_v;
        s.i.halt     = halt_v;
        s.i.mem_ack  = o.mem_req ? ack_v : (ack_v | ($urandom_range(0, 3) == 0));
        s.i.exc_done = o.exc_go ? done_v : ($urandom_range(0, 3) == 0);
        s.i.src      = cur_src;
        s.i.dst      = cur_dst;
        s.o          = o;
        s.as_care    = as_care;
        plan.push_back(s);
    endfunction

    // kind: 0 acked after w waits, 1 never acked (bus error), 2 reset after w waits.
    function automatic int access(logic [1:0] ph, logic [1:0] as, outs_t extra,
                                  int w, int kind);
        outs_t o;
        int    n;
        n = (kind == 1) ? TMO_MAX : w + 1;
        for (int k = 0; k < n; k++) begin
            o = base(ph);
            o.mem_req  = 1'b1;
            o.addr_sel = as;
            if (k == 0) o = outs_t'(o | extra);
            add(o, (kind == 2) && (k == n - 1), 1'b0, (kind == 0) && (k == n - 1), 1'b0, 1'b1);
        end
        if (kind == 1) begin
            o = base(F);
            o.fi0     = 1'b1;
            o.bus_err = 1'b1;
            add(o, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            next_fi0 = 1'b0;
        end else if (kind == 2) begin
            o = base(F);
            o.fi0 = 1'b1;
            add(o, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
            next_fi0 = 1'b0;
        end
        return kind;
    endfunction

    function automatic void reset_seq(int hold);
        outs_t o;
        o = base(F);
        o.fi0 = 1'b1;
        add(o, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k <= hold; k++) begin
            o = base(F);
            o.fi0 = (k == 0);
            add(o, 1'b0, (k < hold), 1'b0, 1'b0, (k == 0));
        end
        next_fi0 = 1'b0;
    endfunction

    function automatic void instr(logic [1:0] src, logic [1:0] dst, int fail_idx,
                                  int fail_kind, int exc_d, int hold);
        outs_t      o, extra, none;
        logic [1:0] m;
        int         acc;
        cur_src = src;
        cur_dst = dst;
        none    = '0;
        extra   = '0;
        extra.fi0 = next_fi0;
        if (access(F, 2'd0, extra, waits[0], (fail_idx == 0) ? fail_kind : 0) != 0) return;
        acc = 1;
        o = base(F);
        o.ir_ld = 1'b1;
        add(o, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int p = 1; p <= 2; p++) begin
            m = (p == 1) ? src : dst;
            if (m == 2'd0) continue;
            extra = '0;
            if (p == 1) extra.src0 = 1'b1;
            else        extra.dst0 = 1'b1;
            for (int j = 0; j < ((m == 2'd3) ? 2 : 1); j++) begin
                if (access(2'(p), (j == 0) ? 2'd1 : 2'd2, (j == 0) ? extra : none,
                           waits[acc], (acc == fail_idx) ? fail_kind : 0) != 0) return;
                acc++;
                if (m == 2'd3 && j == 0) add(base(2'(p)), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            end
            o = base(2'(p));
            o.opr_ld  = 1'b1;
            o.reg_inc = (m == 2'd2);
            add(o, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        for (int k = 0; k <= exc_d; k++) begin
            o = base(E);
            o.exc_go = 1'b1;
            o.exc0   = (k == 0);
            add(o, 1'b0, (hold > 0), 1'b0, (k == exc_d), 1'b0);
        end
        for (int k = 0; k < hold; k++) begin
            o = base(F);
            o.fi0 = (k == 0);
            add(o, 1'b0, (k < hold - 1), 1'b0, 1'b0, 1'b0);
        end
        next_fi0 = (hold == 0);
    endfunction

    task automatic applyStimulus(input ins_t i);
        rst         = i.rst;
        halt        = i.halt;
        mem_ack     = i.mem_ack;
        exc_done    = i.exc_done;
        ir_src_mode = i.src;
        ir_dst_mode = i.dst;
    endtask

    task automatic checkOutput(input step_t s);
        outs_t obs, mask;
        obs  = {mem_req, addr_sel, ir_ld, opr_ld, reg_inc, exc_go,
                fi0, src0, dst0, exc0, phase, bus_err};
        mask = '1;
        if (!s.as_care) mask.addr_sel = 2'b00;
        checks++;
        assert ((obs & mask) === (s.o & mask)) else begin
            errors++;
            $error("[TB] FAIL outputs cycle %0d observed=%b expected=%b (req,as,irld,oprld,inc,go,fi0,src0,dst0,exc0,ph,berr)",
                   cyc, obs & mask, s.o & mask);
        end
    endtask

    initial begin
        step_t s;
        int    r, kind, fidx;
        logic [1:0] rs, rd;

        rst = 1'b1; halt = 1'b0; mem_ack = 1'b0; exc_done = 1'b0;
        ir_src_mode = 2'd0; ir_dst_mode = 2'd0;
        cur_src = 2'd0; cur_dst = 2'd0; next_fi0 = 1'b0;

        reset_seq(0);
        waits = '{2, 0, 0, 0, 0};
        instr(2'd0, 2'd0, -1, 0, 1, 0);
        waits = '{1, 0, 3, 1, 2};
        instr(2'd3, 2'd2, -1, 0, 0, 0);
        waits = '{0, 0, 0, 0, 0};
        instr(2'd0, 2'd0, 0, 1, 0, 0);
        waits = '{14, 0, 0, 0, 0};
        instr(2'd1, 2'd0, -1, 0, 0, 0);
        waits = '{0, 0, 0, 0, 0};
        instr(2'd2, 2'd0, 1, 1, 0, 0);
        waits = '{0, 14, 2, 0, 0};
        instr(2'd1, 2'd1, -1, 0, 2, 8);
        waits = '{1, 3, 0, 0, 0};
        instr(2'd3, 2'd0, 1, 2, 0, 0);

        for (int n = 0; n < 40; n++) begin
            for (int a = 0; a < 5; a++) begin
                r = $urandom_range(0, 9);
                waits[a] = (r == 9) ? 14 : $urandom_range(0, 4);
            end
            r    = $urandom_range(0, 9);
            kind = (r == 0) ? 1 : (r == 1) ? 2 : 0;
            fidx = (kind == 0) ? -1 : $urandom_range(0, 4);
            rs   = 2'($urandom_range(0, 3));
            rd   = 2'($urandom_range(0, 3));
            instr(rs, rd, fidx, kind, $urandom_range(0, 3),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
        end

        @(posedge clk);
        #1;
        while (plan.size() > 0) begin
            s = plan.pop_front();
            checkOutput(s);
            applyStimulus(s.i);
            @(posedge clk);
            #1;
            cyc++;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
